// File: rtl/shift_reg_burst_if.sv
// Signal bundle for shift_reg_burst: shift strobe, mode/burst control, parallel load and results.
interface shift_reg_burst_if #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned CNT_W = 5
);
    logic             clk_in;
    logic             serial_in;
    logic [1:0]       mode;
    logic             set;
    logic [WIDTH-1:0] preset_value;
    logic             start;
    logic [CNT_W-1:0] shift_len;
    logic [WIDTH-1:0] out;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output clk_in, serial_in, mode, set, preset_value, start, shift_len,
        input  out, serial_out, busy, done
    );

    modport slave (
        input  clk_in, serial_in, mode, set, preset_value, start, shift_len,
        output out, serial_out, busy, done
    );
endinterface

// File: rtl/shift_reg_burst.sv
// Strobe-driven shift register with shift-in, rotate, hold and counted-burst modes.
// One shift per rising edge of the qzt-synchronous clk_in strobe.
module shift_reg_burst #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned CNT_W = 5,
    parameter bit          DIR   = 1'b0
) (
    input logic              qzt_clk,
    input logic              reset_n,
    shift_reg_burst_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] out_q;
    logic             serial_out_q;
    logic             clk_in_q;
    logic [CNT_W-1:0] cnt_q;

    logic             shift_evt;
    logic             exit_bit;
    logic [WIDTH-1:0] shift_in_d;
    logic [WIDTH-1:0] rotate_d;

    always_comb begin
        shift_evt = bus.clk_in & ~clk_in_q;
        if (DIR) begin
            exit_bit   = out_q[WIDTH-1];
            shift_in_d = {out_q[WIDTH-2:0], bus.serial_in};
            rotate_d   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        end else begin
            exit_bit   = out_q[0];
            shift_in_d = {bus.serial_in, out_q[WIDTH-1:1]};
            rotate_d   = {out_q[0], out_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge qzt_clk) begin
        // Strobe history runs through reset and set so release never sees a false edge.
        clk_in_q <= bus.clk_in;
        if (!reset_n) begin
            state_q      <= StIdle;
            out_q        <= '0;
            serial_out_q <= 1'b0;
            cnt_q        <= '0;
        end else if (bus.set) begin
            out_q   <= bus.preset_value;
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.mode == 2'b10) begin
                        if (bus.start) begin
                            if (bus.shift_len != '0) begin
                                cnt_q   <= bus.shift_len;
                                state_q <= StBusy;
                            end else begin
                                state_q <= StDone;
                            end
                        end
                    end else if (shift_evt && bus.mode == 2'b00) begin
                        out_q        <= shift_in_d;
                        serial_out_q <= exit_bit;
                    end else if (shift_evt && bus.mode == 2'b01) begin
                        out_q        <= rotate_d;
                        serial_out_q <= exit_bit;
                    end
                end
                StBusy: begin
                    if (shift_evt) begin
                        out_q        <= shift_in_d;
                        serial_out_q <= exit_bit;
                        cnt_q        <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.out        = out_q;
    assign bus.serial_out = serial_out_q;
    assign bus.busy       = (state_q == StBusy);
    assign bus.done       = (state_q == StDone);

endmodule

// File: tb/tb_shift_reg_burst.sv
// Directed bench for shift_reg_burst: expectations queued on stimulus, popped on observation.
module tb_shift_reg_burst;

    logic qzt_clk = 1'b0;
    logic reset_n;

    always #5 qzt_clk = ~qzt_clk;

    shift_reg_burst_if #(.WIDTH(31), .CNT_W(5)) bif_a ();
    shift_reg_burst_if #(.WIDTH(8), .CNT_W(3)) bif_b ();

    shift_reg_burst #(.WIDTH(31), .CNT_W(5), .DIR(1'b0)) u_dut_a (
        .qzt_clk (qzt_clk),
        .reset_n (reset_n),
        .bus     (bif_a)
    );

    shift_reg_burst #(.WIDTH(8), .CNT_W(3), .DIR(1'b1)) u_dut_b (
        .qzt_clk (qzt_clk),
        .reset_n (reset_n),
        .bus     (bif_b)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge qzt_clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    logic [30:0] p;

    initial begin
        reset_n            = 1'b0;
        bif_a.clk_in       = 1'b1;
        bif_a.serial_in    = 1'b1;
        bif_a.mode         = 2'b00;
        bif_a.set          = 1'b0;
        bif_a.preset_value = '0;
        bif_a.start        = 1'b0;
        bif_a.shift_len    = '0;
        bif_b.clk_in       = 1'b0;
        bif_b.serial_in    = 1'b0;
        bif_b.mode         = 2'b11;
        bif_b.set          = 1'b0;
        bif_b.preset_value = '0;
        bif_b.start        = 1'b0;
        bif_b.shift_len    = '0;

        // Reset with strobe held high, then release: no shift on first cycle.
        repeat (3) tick();
        push("rst_out", 32'h0);  chk({1'b0, bif_a.out});
        push("rst_busy", 32'h0); chk({31'h0, bif_a.busy});
        push("rst_done", 32'h0); chk({31'h0, bif_a.done});
        reset_n = 1'b1;
        tick();
        push("rel_out", 32'h0);  chk({1'b0, bif_a.out});
        push("rel_sout", 32'h0); chk({31'h0, bif_a.serial_out});
        push("rel_busy", 32'h0); chk({31'h0, bif_a.busy});

        // Free shift-in, right.
        bif_a.clk_in       = 1'b0;
        bif_a.set          = 1'b1;
        bif_a.preset_value = 31'h0000_0001;
        tick();
        bif_a.set = 1'b0;
        push("set_out", 32'h1); chk({1'b0, bif_a.out});
        bif_a.clk_in = 1'b1;
        tick();
        push("shin_out", 32'h4000_0000); chk({1'b0, bif_a.out});
        push("shin_sout", 32'h1);        chk({31'h0, bif_a.serial_out});
        bif_a.clk_in = 1'b0;
        tick();

        // Rotate a full turn.
        p                  = 31'h1234_5678;
        bif_a.mode         = 2'b01;
        bif_a.set          = 1'b1;
        bif_a.preset_value = p;
        tick();
        bif_a.set = 1'b0;
        for (int i = 0; i < 31; i++) begin
            bif_a.clk_in = 1'b1;
            tick();
            push($sformatf("rot_sout%0d", i), {31'h0, p[i]});
            chk({31'h0, bif_a.serial_out});
            bif_a.clk_in = 1'b0;
            tick();
        end
        push("rot_out", {1'b0, p}); chk({1'b0, bif_a.out});

        // Burst of 5 followed by 3 ignored edges.
        bif_a.mode         = 2'b10;
        bif_a.set          = 1'b1;
        bif_a.preset_value = '0;
        tick();
        bif_a.set       = 1'b0;
        bif_a.serial_in = 1'b1;
        bif_a.shift_len = 5'd5;
        bif_a.start     = 1'b1;
        tick();
        bif_a.start = 1'b0;
        push("bst_busy_rise", 32'h1); chk({31'h0, bif_a.busy});
        for (int i = 1; i <= 8; i++) begin
            bif_a.clk_in = 1'b1;
            tick();
            push($sformatf("bst_busy%0d", i), (i < 5) ? 32'h1 : 32'h0);
            chk({31'h0, bif_a.busy});
            push($sformatf("bst_done%0d", i), (i == 5) ? 32'h1 : 32'h0);
            chk({31'h0, bif_a.done});
            bif_a.clk_in = 1'b0;
            tick();
            push($sformatf("bst_done_lo%0d", i), 32'h0); chk({31'h0, bif_a.done});
        end
        push("bst_out", 32'h7C00_0000); chk({1'b0, bif_a.out});

        // Zero-length burst.
        bif_a.shift_len = 5'd0;
        bif_a.start     = 1'b1;
        tick();
        bif_a.start = 1'b0;
        push("z_done", 32'h1); chk({31'h0, bif_a.done});
        push("z_busy", 32'h0); chk({31'h0, bif_a.busy});
        tick();
        push("z_done_lo", 32'h0);     chk({31'h0, bif_a.done});
        push("z_out", 32'h7C00_0000); chk({1'b0, bif_a.out});

        // Burst of 10 aborted by set after the third edge.
        bif_a.shift_len = 5'd10;
        bif_a.start     = 1'b1;
        tick();
        bif_a.start = 1'b0;
        repeat (3) begin
            bif_a.clk_in = 1'b1;
            tick();
            bif_a.clk_in = 1'b0;
            tick();
        end
        push("ab_busy_pre", 32'h1); chk({31'h0, bif_a.busy});
        bif_a.set          = 1'b1;
        bif_a.preset_value = 31'h2AAA_5555;
        tick();
        bif_a.set = 1'b0;
        push("ab_out", 32'h2AAA_5555); chk({1'b0, bif_a.out});
        push("ab_busy", 32'h0);        chk({31'h0, bif_a.busy});
        push("ab_done", 32'h0);        chk({31'h0, bif_a.done});
        bif_a.clk_in = 1'b1;
        tick();
        push("ab_done2", 32'h0);        chk({31'h0, bif_a.done});
        push("ab_idle_out", 32'h2AAA_5555); chk({1'b0, bif_a.out});
        bif_a.clk_in = 1'b0;
        tick();

        // Reset in the middle of a burst.
        bif_a.shift_len = 5'd5;
        bif_a.start     = 1'b1;
        tick();
        bif_a.start = 1'b0;
        repeat (2) begin
            bif_a.clk_in = 1'b1;
            tick();
            bif_a.clk_in = 1'b0;
            tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        push("mr_out", 32'h0);  chk({1'b0, bif_a.out});
        push("mr_sout", 32'h0); chk({31'h0, bif_a.serial_out});
        push("mr_busy", 32'h0); chk({31'h0, bif_a.busy});
        tick();
        push("mr_done", 32'h0); chk({31'h0, bif_a.done});

        // Left-shift instance, WIDTH 8.
        bif_b.mode         = 2'b00;
        bif_b.set          = 1'b1;
        bif_b.preset_value = 8'h81;
        tick();
        bif_b.set       = 1'b0;
        bif_b.serial_in = 1'b0;
        bif_b.clk_in    = 1'b1;
        tick();
        push("l_out", 32'h02);  chk({24'h0, bif_b.out});
        push("l_sout", 32'h1);  chk({31'h0, bif_b.serial_out});
        bif_b.clk_in = 1'b0;
        tick();

        push("sb_drained", 32'h0); chk(32'(sb.size() - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_reg_burst.md
# shift_reg_burst

Parametrised successor to the 31-bit serial shift register, clocked from the board quartz clock `qzt_clk`. It detects rising edges on a slow, qzt-synchronous `clk_in` strobe and applies one shift per edge. Shift direction and width are set by parameters. Free-run shift-in, rotate, hold and counted-burst modes are selectable at run time. A burst controller shifts exactly N bits, then pulses `done`, so the block can serve serial links to DAC/ADC and front-panel peripherals without an external bit counter.

## Interface
Parameters:
- `WIDTH`, default 31: register width, ≥ 2.
- `CNT_W`, default 5: burst counter width; burst length is 0..2^CNT_W−1.
- `DIR`, default 0: 0 = right shift (bit exits `out[0]`, new bit enters `out[WIDTH-1]`); 1 = left shift (exits `out[WIDTH-1]`, enters `out[0]`).

Ports:
- `qzt_clk`, in, 1: single clock; all logic is on its rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `clk_in`, in, 1: shift strobe, synchronous to `qzt_clk`; each 0→1 transition is one shift event.
- `serial_in`, in, 1: bit shifted in (shift-in and burst modes).
- `mode`, in, 2: 00 free shift-in, 01 free rotate, 10 burst, 11 hold.
- `set`, in, 1: parallel load of `preset_value`.
- `preset_value`, in, WIDTH: parallel load data.
- `start`, in, 1: burst start request; honoured only in IDLE with `mode`=10.
- `shift_len`, in, CNT_W: number of bits in the burst, sampled at start.
- `out`, out, WIDTH: register contents.
- `serial_out`, out, 1: last bit shifted out, held between shifts.
- `busy`, out, 1: high while a burst is in progress.
- `done`, out, 1: one-cycle pulse when a burst completes.

## Operation
- Edge detect:
  - `edge` = `clk_in` & !`clk_in_q`.
  - `clk_in_q` samples `clk_in` every cycle, including during reset and `set`, so a high `clk_in` at reset release does not give a false edge.
- Priority per cycle: `reset_n`=0 > `set` > shift event > hold.
- Reset values: `out`=0, `serial_out`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- `set`:
  - `out` ← `preset_value`; `serial_out` is unchanged.
  - Any burst is aborted: state returns to IDLE and no `done` is issued.
  - An edge coinciding with `set` is discarded.
- Shift step on `edge`, with `e` the exiting bit:
  - `serial_out` ← `e`.
  - `out` moves one place in direction `DIR`.
  - The entering bit is `serial_in` (shift-in and burst) or `e` (rotate).
- State machine: IDLE, BUSY, DONE.
  - IDLE:
    - `mode`=00: every edge performs a shift-in step.
    - `mode`=01: every edge performs a rotate step.
    - `mode`=11: edges are ignored.
    - `mode`=10: edges are ignored. `start`=1 with `shift_len`≠0 loads the counter and goes to BUSY. `start`=1 with `shift_len`=0 goes to DONE with no shift.
  - BUSY:
    - Each edge performs a shift-in step and decrements the counter.
    - The edge taken with counter=1 moves to DONE.
    - `mode` and `start` are ignored while BUSY; mode is sampled only at start.
  - DONE: `done`=1 for exactly one cycle, then IDLE. Edges in DONE are ignored.
- `busy` = (state==BUSY); `done` = (state==DONE). Both are registered state decodes.
- Counter arithmetic is unsigned, CNT_W bits, and never decrements below 1 in BUSY, so it cannot wrap.

## Timing
- Shift latency:
  - An edge sampled at rising edge k (`clk_in`=1, `clk_in_q`=0) updates `out` and `serial_out`, visible after edge k.
  - There is one shift per `clk_in` pulse regardless of pulse width.
  - `clk_in` must be low for at least one `qzt_clk` cycle between pulses.
- `set`: `out`=`preset_value` is visible one cycle after `set` is sampled.
- Burst timing:
  - `busy` rises the cycle after `start` is sampled.
  - After the N-th edge, `busy` falls and `done` pulses in the same following cycle.
  - `done` lasts one cycle; `start` may be reissued in the cycle after `done`.
- Zero-length burst: `done` pulses the cycle after `start`; `busy` stays low.
- `reset_n` low mid-burst: all outputs return to their reset values at the next edge and no `done` is issued.
- `start` held high in IDLE with `mode`=10 starts back-to-back bursts: DONE → IDLE → BUSY.

## Test plan
- Reset with `clk_in` held high, then release: `out`=0, `serial_out`=0, `busy`=0, and no shift occurs on the first cycle.
- `WIDTH`=31, `DIR`=0, `mode`=00, `preset_value`=31'h0000_0001, then one edge with `serial_in`=1: `out`=31'h4000_0000, `serial_out`=1.
- `mode`=01, `preset_value`=31'h1234_5678, then 31 edges: `out` returns to 31'h1234_5678, and `serial_out` follows the bits out[0], out[1], … of the preset.
- `mode`=10, `shift_len`=5, `serial_in`=1, `out`=0, start, then 8 edges:
  - Exactly 5 shifts: `out`=31'h7C00_0000.
  - `busy` is high across the 5 edges, then `done` is one cycle wide.
  - Edges 6–8 are ignored.
- `shift_len`=0 start: `done` pulses the next cycle, `busy` never rises, `out` is unchanged. A separate burst of 10 with `set` asserted after edge 3: `out`=`preset_value`, `busy`=0, no `done`.
- `DIR`=1, `WIDTH`=8, `mode`=00, `preset_value`=8'h81, one edge with `serial_in`=0: `out`=8'h02, `serial_out`=1.
